regfile_write_scheduler: RTL
============================

Name: regfile_write_scheduler

Overview:
Sequences and shares the single write port of the 8x8 register file. After reset, and on request, it runs a clear sweep that writes CLEAR_VAL into every register. It then round-robin arbitrates three write requesters (e.g. ALU writeback, load path, switch/debug input) onto the register file's write address, data and enable inputs. Outputs are registered, so the register file sees one clean write per cycle at most.

Parameters:
DATA_W, 8, register data width
NREG, 8, number of registers; addresses 0..NREG-1
ADDR_W, 3, write address width (log2 NREG)
CLEAR_VAL, 8'h00, value written to every register during a clear sweep

Ports:
clk  input  1  clock; all state changes on the rising edge
reset  input  1  synchronous, active-high reset
clear  input  1  single-cycle pulse; restarts the clear sweep (honoured only in RUN)
req  input  3  req[i]=1: requester i has a pending write
req_addr0, req_addr1, req_addr2  input  ADDR_W each  target register of requester i
req_data0, req_data1, req_data2  input  DATA_W each  write data of requester i
gnt  output  3  one-hot, combinational; gnt[i]=1 means requester i's write is accepted this cycle
busy  output  1  1 while in the CLEAR state
rf_enable  output  1  registered; register file write enable
rf_addr  output  ADDR_W  registered; drives the register file address decoder input
rf_data  output  DATA_W  registered; register file write data

Behaviour:
- States: CLEAR and RUN, plus clr_cnt (ADDR_W bits) and rr_last (index of the last granted requester).
- reset=1 at an edge: state=CLEAR, clr_cnt=0, rr_last=2, rf_enable=0, rf_addr=0, rf_data=0. reset has priority over every other input.
- CLEAR state:
  - busy=1 and gnt=000; req is ignored and nothing is queued.
  - Each edge registers rf_enable=1, rf_addr=clr_cnt, rf_data=CLEAR_VAL, then increments clr_cnt.
  - On the edge where clr_cnt=NREG-1: state goes to RUN and clr_cnt returns to 0.
  - The sweep is exactly NREG consecutive write cycles, addresses 0..NREG-1 in order.
- RUN state:
  - busy=0.
  - gnt selects the first asserted req[i] searching from (rr_last+1) mod 3 upward with wrap.
  - gnt=000 when req=000.
  - A transfer occurs on the edge where gnt[i]=1:
    - rf_enable<=1, rf_addr<=req_addr_i, rf_data<=req_data_i, rr_last<=i.
  - An edge with no transfer registers rf_enable<=0; rf_addr and rf_data hold their values.
- Latency: request accepted in cycle N; rf_* valid during cycle N+1; register written at the end of N+1.
- Handshake:
  - A requester holds req, addr and data stable until it sees gnt[i]=1.
  - It deasserts req in the following cycle unless it has a new write.
  - req still high after a grant is treated as a new request.
- Throughput: one write per cycle. With all three requesting continuously, each is granted every 3rd cycle (no starvation).
- Same-address writes from two requesters are serialized in grant order; the last granted value wins.
- clear=1 in RUN:
  - state=CLEAR and clr_cnt=0 at that edge; gnt=000 in that cycle, so no transfer occurs.
  - Pending requests wait until the sweep ends.
  - rr_last is not changed.
- clear=1 in CLEAR: ignored; the current sweep continues.
- reset mid-sweep or mid-transfer: state returns to CLEAR and rf_enable=0 at that edge. The pending write is dropped, and the sweep restarts from address 0 after reset deasserts.
- Register file address/data outputs carry no X after reset.

Test Plan:
1. Hold reset for 2 cycles, then release:
   - next 8 edges give rf_enable=1 with rf_addr=0,1,...,7 and rf_data=00; busy=1 throughout;
   - then busy=0, rf_enable=0, gnt=000.
2. In RUN, req=001 with req_addr0=5 and req_data0=A5 for 1 cycle:
   - gnt=001 in the same cycle;
   - next cycle rf_enable=1, rf_addr=5, rf_data=A5;
   - the cycle after, rf_enable=0.
3. req=111 held for 6 cycles with distinct addresses:
   - gnt sequence 001,010,100,001,010,100;
   - rf_addr follows with 1-cycle lag;
   - rf_enable=1 on 6 consecutive cycles.
4. req=010 asserted 2 cycles after reset release:
   - gnt=000 until busy falls;
   - gnt=010 on the first RUN cycle;
   - rf_addr/rf_data of requester 1 on the next cycle.
5. clear pulse while req=100 is held:
   - gnt=000 in the pulse cycle;
   - 8-cycle sweep writing 00 to addresses 0..7;
   - then gnt=100 and the requester 2 write lands after the sweep.
6. reset asserted during sweep cycle 4 (rf_addr=3):
   - rf_enable=0 on the reset edge;
   - after release the sweep restarts at rf_addr=0 and runs a full 8 cycles.

Source files
------------

// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler
//   Owns the single write port of the register file. After reset, or on a
//   clear pulse, it sweeps CLEAR_VAL into every register. Otherwise it
//   round-robin arbitrates three write requesters onto the registered
//   rf_enable/rf_addr/rf_data outputs. The register file sees at most one
//   write per cycle.
//
// Ports
//   clk                  clock, rising edge
//   reset                synchronous, active-high reset
//   clear                single-cycle pulse, restarts the clear sweep (RUN only)
//   req[2:0]             pending write per requester
//   req_addr0..2         target register per requester
//   req_data0..2         write data per requester
//   gnt[2:0]             one-hot combinational grant, transfer on this edge
//   busy                 high while sweeping
//   rf_enable/addr/data  registered register file write port
module regfile_write_scheduler #(
   parameter int unsigned             DATA_W    = 8,
   parameter int unsigned             NREG      = 8,
   parameter int unsigned             ADDR_W    = 3,
   parameter logic [DATA_W-1:0]       CLEAR_VAL = 8'h00
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic [2:0]        req,
   input  logic [ADDR_W-1:0] req_addr0,
   input  logic [ADDR_W-1:0] req_addr1,
   input  logic [ADDR_W-1:0] req_addr2,
   input  logic [DATA_W-1:0] req_data0,
   input  logic [DATA_W-1:0] req_data1,
   input  logic [DATA_W-1:0] req_data2,
   output logic [2:0]        gnt,
   output logic              busy,
   output logic              rf_enable,
   output logic [ADDR_W-1:0] rf_addr,
   output logic [DATA_W-1:0] rf_data
);

   localparam logic StClear = 1'b0;
   localparam logic StRun   = 1'b1;

   logic              state_q,     state_d;
   logic [ADDR_W-1:0] clr_cnt_q,   clr_cnt_d;
   logic [1:0]        rr_last_q,   rr_last_d;
   logic              rf_enable_q, rf_enable_d;
   logic [ADDR_W-1:0] rf_addr_q,   rf_addr_d;
   logic [DATA_W-1:0] rf_data_q,   rf_data_d;

   logic [1:0]        rr_start;
   logic [1:0]        gnt_idx;
   logic              gnt_any;
   logic [2:0]        cand;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;

   // Search starts one past the last winner, wrapping modulo 3.
   assign rr_start = (rr_last_q == 2'd2) ? 2'd0 : rr_last_q + 2'd1;

   always_comb begin
      gnt     = 3'b000;
      gnt_idx = 2'd0;
      gnt_any = 1'b0;
      cand    = 3'd0;
      // No grant during reset, in the clear-pulse cycle, or while sweeping.
      if (state_q == StRun && !clear && !reset) begin
         for (int k = 0; k < 3; k++) begin
            cand = 3'(rr_start) + 3'(k);
            if (cand >= 3'd3) begin
               cand = cand - 3'd3;
            end
            if (!gnt_any && req[cand[1:0]]) begin
               gnt_any         = 1'b1;
               gnt_idx         = cand[1:0];
               gnt[cand[1:0]]  = 1'b1;
            end
         end
      end
   end

   always_comb begin
      sel_addr = req_addr0;
      sel_data = req_data0;
      case (gnt_idx)
         2'd1: begin
            sel_addr = req_addr1;
            sel_data = req_data1;
         end
         2'd2: begin
            sel_addr = req_addr2;
            sel_data = req_data2;
         end
         default: begin
            sel_addr = req_addr0;
            sel_data = req_data0;
         end
      endcase
   end

   always_comb begin
      state_d     = state_q;
      clr_cnt_d   = clr_cnt_q;
      rr_last_d   = rr_last_q;
      rf_enable_d = 1'b0;
      rf_addr_d   = rf_addr_q;
      rf_data_d   = rf_data_q;
      if (state_q == StClear) begin
         rf_enable_d = 1'b1;
         rf_addr_d   = clr_cnt_q;
         rf_data_d   = CLEAR_VAL;
         if (clr_cnt_q == ADDR_W'(NREG - 1)) begin
            state_d   = StRun;
            clr_cnt_d = '0;
         end else begin
            clr_cnt_d = clr_cnt_q + 1'b1;
         end
      end else if (clear) begin
         state_d   = StClear;
         clr_cnt_d = '0;
      end else if (gnt_any) begin
         rf_enable_d = 1'b1;
         rf_addr_d   = sel_addr;
         rf_data_d   = sel_data;
         rr_last_d   = gnt_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StClear;
         clr_cnt_q   <= '0;
         rr_last_q   <= 2'd2;
         rf_enable_q <= 1'b0;
         rf_addr_q   <= '0;
         rf_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         clr_cnt_q   <= clr_cnt_d;
         rr_last_q   <= rr_last_d;
         rf_enable_q <= rf_enable_d;
         rf_addr_q   <= rf_addr_d;
         rf_data_q   <= rf_data_d;
      end
   end

   assign busy      = (state_q == StClear);
   assign rf_enable = rf_enable_q;
   assign rf_addr   = rf_addr_q;
   assign rf_data   = rf_data_q;

endmodule
